icg_ctrl: RTL and testbench



---
 rtl/icg_ctrl.sv | 122 ++++++++++++
 tb/tb_icg_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/icg_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// icg_ctrl : automatic ICG enable controller (idle gating, timed wake, scan
//            override). Optional ICG_CTRL_STATS_EN adds the GATED_CNT counter.
// Revision : 1.0
// ----------------------------------------------------------------------------
module icg_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RN,
  input  logic        BUSY,
  input  logic        REQ,
  input  logic        SCAN_MODE,
  output logic        E,
  output logic        GNT,
  output logic        GATED
`ifdef ICG_CTRL_STATS_EN
  ,
  output logic [15:0] GATED_CNT
`endif
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [3:0]    WAKE_LAST = 4'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_GATED = 2'd1,
    ST_WAKE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [3:0]      wake_q, wake_d;
  logic            e_q, gnt_q, gated_q;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_RUN;
      idle_q  <= '0;
      wake_q  <= '0;
      e_q     <= 1'b1;
      gnt_q   <= 1'b1;
      gated_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      wake_q  <= wake_d;
      // Outputs come straight from flops, decoded from the next state.
      e_q     <= (state_d != ST_GATED);
      gnt_q   <= (state_d == ST_RUN);
      gated_q <= (state_d == ST_GATED);
    end
  end

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    wake_d  = wake_q;
    if (SCAN_MODE) begin
      state_d = ST_RUN;
      idle_d  = '0;
      wake_d  = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (BUSY || REQ) begin
            idle_d = '0;
          end else if (idle_q == IDLE_LAST) begin
            state_d = ST_GATED;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
        ST_GATED: begin
          if (REQ) begin
            state_d = ST_WAKE;
            wake_d  = '0;
          end
        end
        ST_WAKE: begin
          if (wake_q == WAKE_LAST) begin
            state_d = ST_RUN;
            wake_d  = '0;
          end else begin
            wake_d = wake_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_RUN;
          idle_d  = '0;
          wake_d  = '0;
        end
      endcase
    end
  end

  // Scan override is the only combinational term on E.
  assign E     = e_q | SCAN_MODE;
  assign GNT   = gnt_q;
  assign GATED = gated_q;

`ifdef ICG_CTRL_STATS_EN
  logic [15:0] gated_cnt_q;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      gated_cnt_q <= '0;
    end else if (state_q == ST_GATED && gated_cnt_q != 16'hFFFF) begin
      gated_cnt_q <= gated_cnt_q + 16'd1;
    end
  end

  assign GATED_CNT = gated_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icg_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_icg_ctrl : vector table, directed corner cases and randomized run
//               against a behavioural model of icg_ctrl.
// ----------------------------------------------------------------------------
module tb_icg_ctrl;

  localparam int IDLE_CYCLES = 16;
  localparam int WAKE_CYCLES = 2;

  logic CLK, RN, BUSY, REQ, SCAN_MODE;
  logic E, GNT, GATED;
`ifdef ICG_CTRL_STATS_EN
  logic [15:0] GATED_CNT;
`endif

  icg_ctrl #(.IDLE_CYCLES(IDLE_CYCLES), .WAKE_CYCLES(WAKE_CYCLES)) dut (
    .CLK       (CLK),
    .RN        (RN),
    .BUSY      (BUSY),
    .REQ       (REQ),
    .SCAN_MODE (SCAN_MODE),
    .E         (E),
    .GNT       (GNT),
    .GATED     (GATED)
`ifdef ICG_CTRL_STATS_EN
    ,
    .GATED_CNT (GATED_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic busy;
    logic req;
    logic scan;
    logic [2:0] exp;  // {E, GNT, GATED}
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add_n(input int n, input logic b, input logic r,
                                input logic s, input logic e, input logic g,
                                input logic gt);
    vec_t v;
    v.busy = b; v.req = r; v.scan = s; v.exp = {e, g, gt};
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [2:0] exp);
    checks++;
    if ({E, GNT, GATED} !== exp) begin
      errors++;
      $display("FAIL %s: {E,GNT,GATED} got %b expected %b at %0t",
               name, {E, GNT, GATED}, exp, $time);
    end
  endtask

  task automatic step(input logic b, input logic r, input logic s);
    BUSY = b; REQ = r; SCAN_MODE = s;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RN = 1'b0; BUSY = 1'b0; REQ = 1'b0; SCAN_MODE = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset", 3'b110);
    @(negedge CLK);
    RN = 1'b1;
  endtask

  // Behavioural model: the controller is "running", "off" or "waking";
  // gating happens once IDLE_CYCLES quiet cycles have been seen in a row,
  // and waking lasts exactly WAKE_CYCLES cycles.
  typedef enum int {M_RUN, M_OFF, M_WAKING} mode_t;
  mode_t m_mode;
  int    m_quiet;
  int    m_wake_left;
  int    m_off_cycles;

  function automatic void model_reset();
    m_mode = M_RUN; m_quiet = 0; m_wake_left = 0; m_off_cycles = 0;
  endfunction

  function automatic void model_edge(input logic b, input logic r, input logic s);
    if (m_mode == M_OFF && m_off_cycles < 65535) m_off_cycles++;
    if (s) begin
      m_mode = M_RUN; m_quiet = 0; m_wake_left = 0;
    end else if (m_mode == M_RUN) begin
      m_quiet = (b || r) ? 0 : m_quiet + 1;
      if (m_quiet == IDLE_CYCLES) begin
        m_mode  = M_OFF;
        m_quiet = 0;
      end
    end else if (m_mode == M_OFF) begin
      if (r) begin
        m_mode      = M_WAKING;
        m_wake_left = WAKE_CYCLES;
      end
    end else begin
      m_wake_left--;
      if (m_wake_left == 0) m_mode = M_RUN;
    end
  endfunction

  function automatic logic [2:0] model_out(input logic s);
    return {(m_mode != M_OFF) || s, m_mode == M_RUN, m_mode == M_OFF};
  endfunction

  initial begin
    // Reset release, gating latency, wake, restart, REQ drop, collision.
    add_n(15, 0, 0, 0, 1, 1, 0);
    add_n(1,  0, 0, 0, 0, 0, 1);
    add_n(3,  1, 0, 0, 0, 0, 1);
    add_n(2,  0, 1, 0, 1, 0, 0);
    add_n(2,  0, 1, 0, 1, 1, 0);
    add_n(10, 0, 0, 0, 1, 1, 0);
    add_n(1,  1, 0, 0, 1, 1, 0);
    add_n(15, 0, 0, 0, 1, 1, 0);
    add_n(1,  0, 0, 0, 0, 0, 1);
    add_n(1,  0, 1, 0, 1, 0, 0);
    add_n(1,  0, 0, 0, 1, 0, 0);
    add_n(1,  0, 0, 0, 1, 1, 0);
    add_n(15, 0, 0, 0, 1, 1, 0);
    add_n(1,  0, 1, 0, 1, 1, 0);
    add_n(15, 0, 0, 0, 1, 1, 0);
    add_n(1,  0, 0, 0, 0, 0, 1);

    do_reset();
    foreach (vecs[i]) begin
      step(vecs[i].busy, vecs[i].req, vecs[i].scan);
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Scan asserted while gated: E combinationally, RUN after the edge.
    SCAN_MODE = 1'b1;
    #1;
    chk("scan_comb", 3'b001 | 3'b100);
    for (int i = 0; i < 101; i++) begin
      step(0, 0, 1);
      chk($sformatf("scan_hold%0d", i), 3'b110);
    end
    add_n(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 0);
      chk($sformatf("post_scan%0d", i), 3'b110);
    end
    step(0, 0, 0);
    chk("post_scan_gate", 3'b001);

    // Asynchronous reset in the middle of a wake.
    step(0, 1, 0);
    chk("wake_enter", 3'b100);
    #3;
    RN = 1'b0;
    #1;
    chk("async_reset", 3'b110);
`ifdef ICG_CTRL_STATS_EN
    checks++;
    if (GATED_CNT !== 16'd0) begin
      errors++;
      $display("FAIL gated_cnt_reset: got %0d expected 0", GATED_CNT);
    end
`endif
    @(negedge CLK);
    RN = 1'b1;
    for (int i = 0; i < 16; i++) step(0, 0, 0);
    chk("regate", 3'b001);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    chk("still_gated", 3'b001);
`ifdef ICG_CTRL_STATS_EN
    checks++;
    if (GATED_CNT !== 16'd5) begin
      errors++;
      $display("FAIL gated_cnt5: got %0d expected 5", GATED_CNT);
    end
`endif

    // Randomized traffic against the model.
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      logic b, r, s;
      b = ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 29) == 0) || (REQ && !GNT && $urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 199) == 0);
      step(b, r, s);
      model_edge(b, r, s);
      chk($sformatf("rand%0d", i), model_out(s));
`ifdef ICG_CTRL_STATS_EN
      checks++;
      if (GATED_CNT !== 16'(m_off_cycles)) begin
        errors++;
        $display("FAIL rand_cnt%0d: got %0d expected %0d", i, GATED_CNT, m_off_cycles);
      end
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
